time_handoff_receiver: RTL
==========================

# time_handoff_receiver

Receiving end of the time-propagate interface between the 12-hour and 24-hour clock cores. It captures a time word (hours, minutes, AM/PM) broadcast by whichever core is active and normalises it to 24-hour form. It keeps the captured time advancing on the real-time second tick while it waits, so the destination core loads a current time. It then offers the time to the destination through a valid/ack handshake and presents both 24-hour and 12-hour views.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `real_clk`  in  1  one-cycle second tick, synchronous to `clk`.
- `propagate`  in  1  one-cycle capture strobe from the source core.
- `src_is12`  in  1  source format: 1 = 12-hour (`in_isPM`, `in_hours` 1..12); 0 = 24-hour (`in_hours` 0..23).
- `in_isPM`  in  1  PM flag. Ignored when `src_is12`=0.
- `in_hours`  in  5  source hours.
- `in_minutes`  in  6  source minutes, 0..59.
- `dest_req`  in  1  level; destination core requests the held time.
- `load_ack`  in  1  one-cycle acknowledge; destination has loaded the offered time.
- `held_valid`  out  1  a captured time is held (state HOLD or OFFER).
- `load_valid`  out  1  offer active (state OFFER).
- `out24_hours`  out  5  held hours, 0..23.
- `out_minutes`  out  6  held minutes, 0..59.
- `out12_hours`  out  4  held hours in 12-hour form, 1..12.
- `out12_isPM`  out  1  PM flag of the 12-hour view.
- `cap_err`  out  1  one-cycle pulse: capture rejected as out of range.

## Operation
- Internal registers:
  - state: EMPTY, HOLD or OFFER.
  - `hours24` (5b), `minutes` (6b), `seconds` (6b).
- Capture on `propagate`, from any state.
  - Valid input: `src_is12`=1 needs hours 1..12 and minutes ≤ 59; `src_is12`=0 needs hours ≤ 23 and minutes ≤ 59.
  - Conversion when `src_is12`=1:
    - 12 AM → 0.
    - 1..11 AM → h.
    - 12 PM → 12.
    - 1..11 PM → h+12.
  - On valid capture: load `hours24` and `minutes`, clear `seconds` to 0, next state HOLD.
  - On invalid capture: registers and state unchanged, `cap_err` pulses for 1 cycle.
- Advance, in HOLD and OFFER only, on each `real_clk`:
  - `seconds` counts 0..59; on 59 it wraps to 0 and carries to `minutes`.
  - `minutes` wraps 59 → 0 and carries to `hours24`.
  - `hours24` wraps 23 → 0.
  - No advance in EMPTY.
- FSM transitions:
  - EMPTY → HOLD on valid capture.
  - HOLD → OFFER when `dest_req`=1 and there is no capture that cycle.
  - OFFER → EMPTY on `load_ack` with no capture that cycle. The held values stay visible but are stale.
  - OFFER stays in OFFER if `dest_req` drops; the offer is not withdrawn.
  - `load_ack` outside OFFER is ignored.
- Priority in a single cycle: capture > ack > advance.
  - `propagate` together with `real_clk`: the capture wins and `seconds` = 0.
  - Valid `propagate` together with `load_ack` in OFFER: the capture wins, next state HOLD, ack discarded.
  - Invalid `propagate` does not block a same-cycle ack or advance.
- 12-hour view, combinational from the registered `hours24`:
  - 0 → 12 AM.
  - 1..11 → AM.
  - 12 → 12 PM.
  - 13..23 → h-12, PM.
- Width rules: compare before increment so nothing overflows; the 4-bit `out12_hours` is never zero.

## Timing
- Reset (asynchronous, takes effect immediately) gives:
  - state EMPTY; `hours24`, `minutes`, `seconds` = 0.
  - `held_valid`=0, `load_valid`=0, `cap_err`=0.
  - `out24_hours`=0, `out_minutes`=0, `out12_hours`=12, `out12_isPM`=0.
- Reset mid-OFFER drops the offer with no ack required.
- Capture latency is 1 cycle: values and `held_valid` are updated on the edge after `propagate` is sampled.
- Request latency is 1 cycle: `load_valid` rises on the edge after `dest_req` is sampled in HOLD.
- Ack: `load_valid` and `held_valid` fall on the edge sampling `load_ack`.
- An advance is visible 1 cycle after `real_clk`.
- Values may change while `load_valid`=1, through ticks or a re-capture. The destination loads exactly the values present in the cycle it asserts `load_ack`.
- `cap_err` is registered: it pulses on the cycle after the rejected `propagate`.

## Test plan
- Reset, then `propagate` with `src_is12`=1, PM=1, hours 12, minutes 30 → `out24_hours`=12, `out_minutes`=30, `out12_hours`=12, `out12_isPM`=1, `held_valid`=1 one cycle later.
- Capture 12 AM 05 (12-hour) → `out24_hours`=0, `out12_hours`=12, `out12_isPM`=0. Capture 11 PM 59 → 23:59.
- Hold 23:59, issue 60 `real_clk` ticks → 0:00, `out12_hours`=12 AM. 59 ticks alone → still 23:59.
- Handshake: hold 7:15, `dest_req`=1 → `load_valid`=1 next cycle. `load_ack` → `load_valid`=0 and `held_valid`=0 next cycle, and later ticks do not change `out_minutes`.
- Invalid captures: 12-hour hours 0, 12-hour hours 13, 24-hour hours 24, and minutes 60 each produce one `cap_err` pulse with the held time unchanged. Valid `propagate` with `load_ack` in OFFER → state HOLD with the new time.
- Assert `reset` while in OFFER, mid-cycle → outputs go immediately to their reset values. Then `real_clk` ticks without a capture → the time stays 0:00.

Source files
------------

// File: rtl/time_handoff_receiver.sv
// rtl/time_handoff_receiver.sv - captures a propagated time word, keeps it ticking, offers it via valid/ack
// Normalises 12-hour or 24-hour source time to 24-hour form and presents both views.
module time_handoff_receiver (
  input  logic       clk,
  input  logic       reset,
  input  logic       real_clk,
  input  logic       propagate,
  input  logic       src_is12,
  input  logic       in_isPM,
  input  logic [4:0] in_hours,
  input  logic [5:0] in_minutes,
  input  logic       dest_req,
  input  logic       load_ack,
  output logic       held_valid,
  output logic       load_valid,
  output logic [4:0] out24_hours,
  output logic [5:0] out_minutes,
  output logic [3:0] out12_hours,
  output logic       out12_isPM,
  output logic       cap_err
);

  typedef enum logic [1:0] {EMPTY, HOLD, OFFER} state_t;

  state_t     state_q, state_d;
  logic [4:0] hours24_q, hours24_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       cap_err_q, cap_err_d;
  logic       held_valid_q, held_valid_d;
  logic       load_valid_q, load_valid_d;

  logic       in_valid;
  logic [4:0] in_hours24;
  logic       capture;
  logic       ack;
  logic       advance;

  always_comb begin
    in_valid = (in_minutes <= 6'd59) &&
               (src_is12 ? (in_hours >= 5'd1 && in_hours <= 5'd12) : (in_hours <= 5'd23));
    in_hours24 = in_hours;
    if (src_is12) begin
      if (in_hours == 5'd12) begin
        in_hours24 = in_isPM ? 5'd12 : 5'd0;
      end else if (in_isPM) begin
        in_hours24 = in_hours + 5'd12;
      end
    end
  end

  // Capture beats ack, and an accepted ack leaves the handed-off time frozen.
  assign capture = propagate && in_valid;
  assign ack     = (state_q == OFFER) && load_ack;
  assign advance = (state_q != EMPTY) && real_clk && !ack;

  always_comb begin
    state_d   = state_q;
    hours24_d = hours24_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    cap_err_d = propagate && !in_valid;
    if (capture) begin
      hours24_d = in_hours24;
      minutes_d = in_minutes;
      seconds_d = 6'd0;
      state_d   = HOLD;
    end else if (ack) begin
      state_d = EMPTY;
    end else begin
      if (advance) begin
        if (seconds_q == 6'd59) begin
          seconds_d = 6'd0;
          if (minutes_q == 6'd59) begin
            minutes_d = 6'd0;
            hours24_d = (hours24_q == 5'd23) ? 5'd0 : hours24_q + 5'd1;
          end else begin
            minutes_d = minutes_q + 6'd1;
          end
        end else begin
          seconds_d = seconds_q + 6'd1;
        end
      end
      if (state_q == HOLD && dest_req) begin
        state_d = OFFER;
      end
    end
    held_valid_d = (state_d != EMPTY);
    load_valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      hours24_q    <= 5'd0;
      minutes_q    <= 6'd0;
      seconds_q    <= 6'd0;
      cap_err_q    <= 1'b0;
      held_valid_q <= 1'b0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hours24_q    <= hours24_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      cap_err_q    <= cap_err_d;
      held_valid_q <= held_valid_d;
      load_valid_q <= load_valid_d;
    end
  end

  // For 13..23 the low nibble minus 12, taken mod 16, lands exactly on 1..11.
  always_comb begin
    if (hours24_q == 5'd0) begin
      out12_hours = 4'd12;
      out12_isPM  = 1'b0;
    end else if (hours24_q < 5'd12) begin
      out12_hours = hours24_q[3:0];
      out12_isPM  = 1'b0;
    end else if (hours24_q == 5'd12) begin
      out12_hours = 4'd12;
      out12_isPM  = 1'b1;
    end else begin
      out12_hours = hours24_q[3:0] - 4'd12;
      out12_isPM  = 1'b1;
    end
  end

  assign held_valid  = held_valid_q;
  assign load_valid  = load_valid_q;
  assign out24_hours = hours24_q;
  assign out_minutes = minutes_q;
  assign cap_err     = cap_err_q;

endmodule
